// File: rtl/gamma_pkg.sv
// Shared types and constants for the LED gamma blocks: widths, the
// inverse-search state encoding and the fixed forward-curve formula.
package gamma_pkg;

  localparam int LIN_W  = 12;
  localparam int CODE_W = 8;

  localparam logic [CODE_W-1:0] CODE_MAX = 8'hff;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    ROUND  = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Forward curve G(c) = round(4095 * (c/255)^4), evaluated in exact integer
  // arithmetic as floor((2*4095*c^4 + 255^4) / (2*255^4)). An exact .5 cannot
  // occur because the numerator is even and 255^4 is odd, so no tie rule is
  // needed. Only ever called with constant arguments to fill the ROM.
  function automatic logic [LIN_W-1:0] gamma_calc(input int unsigned c);
    logic [63:0] cc;
    logic [63:0] num;
    logic [63:0] q;
    cc  = 64'(c);
    num = (cc * cc * cc * cc * 64'd8190) + 64'd4228250625;
    q   = num / 64'd8456501250;
    return q[LIN_W-1:0];
  endfunction

endpackage

// File: rtl/gamma.sv
// Forward gamma LUT: 8-bit perceptual code in, 12-bit linear intensity out,
// purely combinational. The table is filled from constants at elaboration.
module gamma
  import gamma_pkg::*;
(
  input  logic [CODE_W-1:0] code,
  output logic [LIN_W-1:0]  lin
);

  logic [LIN_W-1:0] rom_s [0:255];

  for (genvar i = 0; i < 256; i++) begin : g_rom
    localparam logic [LIN_W-1:0] G_VAL = gamma_calc(i);
    assign rom_s[i] = G_VAL;
  end

  assign lin = rom_s[code];

endmodule

// File: rtl/inverse_gamma.sv
// Inverse gamma: maps a 12-bit linear intensity back to the 8-bit code whose
// forward value is the largest not exceeding it (or the nearest code when
// ROUND_NEAREST is set). An 8-step binary search shares one forward LUT; a
// single transaction is in flight at a time, with valid/ready on both sides.
module inverse_gamma
  import gamma_pkg::*;
#(
  parameter int ROUND_NEAREST = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [LIN_W-1:0]  in_lin,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CODE_W-1:0] out_code
);

  state_t            state_r;
  logic [LIN_W-1:0]  lin_r;
  logic [CODE_W-1:0] code_r;
  logic [2:0]        bit_r;
  // Forward value of the current floor candidate, so ROUND only needs the
  // single LUT lookup of code+1.
  logic [LIN_W-1:0]  gfloor_r;

  logic [CODE_W-1:0] trial_s;
  logic [CODE_W-1:0] code_inc_s;
  logic [CODE_W-1:0] curve_in_s;
  logic [LIN_W-1:0]  curve_out_s;
  logic              fits_s;
  logic [LIN_W-1:0]  d0_s;
  logic [LIN_W-1:0]  d1_s;
  logic              take_up_s;

  // Trial code, saturated code+1 and the LUT input mux (code+1 only in ROUND).
  always_comb begin
    trial_s    = code_r | (8'd1 << bit_r);
    code_inc_s = code_r;
    curve_in_s = trial_s;
    if (code_r != CODE_MAX) begin
      code_inc_s = code_r + 8'd1;
    end else begin
      code_inc_s = code_r;
    end
    if (state_r == ROUND) begin
      curve_in_s = code_inc_s;
    end else begin
      curve_in_s = trial_s;
    end
  end

  gamma u_gamma (
    .code (curve_in_s),
    .lin  (curve_out_s)
  );

  // Search comparison and nearest-code decision; G(code+1) > lin holds in
  // ROUND, so neither difference can underflow there.
  always_comb begin
    fits_s    = (curve_out_s <= lin_r);
    d0_s      = lin_r - gfloor_r;
    d1_s      = curve_out_s - lin_r;
    take_up_s = 1'b0;
    if ((code_r != CODE_MAX) && (d1_s < d0_s)) begin
      take_up_s = 1'b1;
    end else begin
      take_up_s = 1'b0;
    end
  end

  // Control FSM with registered handshake outputs and result.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_code  <= 8'h00;
      lin_r     <= 12'h000;
      code_r    <= 8'h00;
      bit_r     <= 3'd0;
      gfloor_r  <= 12'h000;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            lin_r    <= in_lin;
            code_r   <= 8'h00;
            bit_r    <= 3'd7;
            gfloor_r <= 12'h000;
            in_ready <= 1'b0;
            state_r  <= SEARCH;
          end else begin
            in_ready <= 1'b1;
          end
        end
        SEARCH: begin
          if (fits_s) begin
            code_r   <= trial_s;
            gfloor_r <= curve_out_s;
          end else begin
            code_r   <= code_r;
          end
          bit_r <= bit_r - 3'd1;
          if (bit_r == 3'd0) begin
            if (ROUND_NEAREST != 0) begin
              state_r <= ROUND;
            end else begin
              state_r   <= DONE;
              out_valid <= 1'b1;
              out_code  <= fits_s ? trial_s : code_r;
            end
          end else begin
            state_r <= SEARCH;
          end
        end
        ROUND: begin
          if (take_up_s) begin
            code_r   <= code_inc_s;
            out_code <= code_inc_s;
          end else begin
            out_code <= code_r;
          end
          out_valid <= 1'b1;
          state_r   <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_r   <= IDLE;
          end else begin
            out_valid <= 1'b1;
          end
        end
        default: begin
          state_r   <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inverse_gamma.sv
// Directed and exhaustive checks of inverse_gamma in floor (u_f) and
// nearest (u_n) configurations against an independent floating-point model.
module tb_inverse_gamma;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;

  logic        iv0 = 1'b0, iv1 = 1'b0;
  logic [11:0] il0 = 12'h000, il1 = 12'h000;
  logic        ordy0 = 1'b0, ordy1 = 1'b0;
  logic        irdy0, irdy1, ov0, ov1;
  logic [7:0]  oc0, oc1;

  int total = 0;
  int bad   = 0;

  int gt [0:255];

  int         lat0, lat1;
  logic [7:0] c0, c1;

  always #5 clk = ~clk;

  inverse_gamma #(.ROUND_NEAREST(0)) u_f (
    .clk(clk), .reset_n(reset_n), .in_valid(iv0), .in_ready(irdy0),
    .in_lin(il0), .out_valid(ov0), .out_ready(ordy0), .out_code(oc0)
  );

  inverse_gamma #(.ROUND_NEAREST(1)) u_n (
    .clk(clk), .reset_n(reset_n), .in_valid(iv1), .in_ready(irdy1),
    .in_lin(il1), .out_valid(ov1), .out_ready(ordy1), .out_code(oc1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic rdy(input int m);
    return (m == 0) ? irdy0 : irdy1;
  endfunction

  function automatic logic vld(input int m);
    return (m == 0) ? ov0 : ov1;
  endfunction

  function automatic logic [7:0] cod(input int m);
    return (m == 0) ? oc0 : oc1;
  endfunction

  task automatic drv_in(input int m, input logic v, input logic [11:0] l);
    if (m == 0) begin iv0 = v; il0 = l; end
    else begin iv1 = v; il1 = l; end
  endtask

  task automatic drv_rdy(input int m, input logic v);
    if (m == 0) ordy0 = v;
    else ordy1 = v;
  endtask

  // Model: largest c with G(c) <= lin.
  function automatic int model_floor(input int l);
    int f;
    f = 0;
    for (int c = 0; c < 256; c++) if (gt[c] <= l) f = c;
    return f;
  endfunction

  function automatic int model_near(input int l);
    int f;
    f = model_floor(l);
    if (f == 255) return f;
    if ((gt[f+1] - l) < (l - gt[f])) return f + 1;
    return f;
  endfunction

  // One transaction: latency counts cycles from the accept cycle to out_valid.
  // in_lin is corrupted right after acceptance to show it is not resampled.
  task automatic send(input int m, input logic [11:0] l, output int lat, output logic [7:0] code);
    int n;
    @(negedge clk);
    drv_in(m, 1'b1, l);
    n = 0;
    while (!rdy(m) && n < 40) begin @(negedge clk); n++; end
    check($sformatf("accept m%0d lin=%0h", m, l), rdy(m), 1);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      drv_in(m, 1'b0, ~l);
    end while (!vld(m) && lat < 40);
    check($sformatf("valid m%0d lin=%0h", m, l), vld(m), 1);
    code = cod(m);
    drv_rdy(m, 1'b1);
    @(negedge clk);
    drv_rdy(m, 1'b0);
  endtask

  initial begin
    int n;
    for (int c = 0; c < 256; c++) begin
      real x;
      x = c / 255.0;
      gt[c] = int'(4095.0 * x * x * x * x);
    end

    // Reset values.
    repeat (3) @(negedge clk);
    check("rst in_ready f", irdy0, 1);
    check("rst out_valid f", ov0, 0);
    check("rst out_code f", oc0, 8'h00);
    check("rst in_ready n", irdy1, 1);
    check("rst out_valid n", ov1, 0);
    check("rst out_code n", oc1, 8'h00);
    reset_n = 1'b1;

    // Floor mode directed vectors.
    send(0, 12'h104, lat0, c0); check("f 104", c0, 8'h80); check("f lat", lat0, 9);
    send(0, 12'h103, lat0, c0); check("f 103", c0, 8'h7f);
    send(0, 12'h000, lat0, c0); check("f 000", c0, 8'h1a);
    send(0, 12'hfff, lat0, c0); check("f fff", c0, 8'hff);
    send(0, 12'hffe, lat0, c0); check("f ffe", c0, 8'hfe);

    // Nearest mode directed vectors.
    send(1, 12'hffe, lat1, c1); check("n ffe", c1, 8'hff);
    send(1, 12'h108, lat1, c1); check("n 108 tie", c1, 8'h80); check("n lat", lat1, 10);
    send(1, 12'h109, lat1, c1); check("n 109", c1, 8'h81);
    send(1, 12'hfff, lat1, c1); check("n fff", c1, 8'hff);
    send(1, 12'h000, lat1, c1); check("n 000", c1, 8'h1a);

    // Backpressure: result held 20 cycles, new in_valid ignored meanwhile.
    @(negedge clk); iv0 = 1'b1; il0 = 12'h524;
    check("bp accept", irdy0, 1);
    @(negedge clk); iv0 = 1'b0;
    n = 0;
    while (!ov0 && n < 40) begin @(negedge clk); n++; end
    check("bp valid", ov0, 1);
    iv0 = 1'b1; il0 = 12'h104;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("bp hold valid", ov0, 1);
      check("bp hold code", oc0, 8'hc0);
      check("bp in_ready", irdy0, 0);
    end
    ordy0 = 1'b1;
    @(negedge clk); ordy0 = 1'b0;
    check("bp release valid", ov0, 0);
    check("bp release in_ready", irdy0, 1);
    n = 0;
    do begin @(negedge clk); n++; iv0 = 1'b0; end while (!ov0 && n < 40);
    check("bp next lat", n, 9);
    check("bp next code", oc0, 8'h80);
    ordy0 = 1'b1;
    @(negedge clk); ordy0 = 1'b0;

    // Reset during the fourth SEARCH cycle.
    @(negedge clk); iv0 = 1'b1; il0 = 12'hfff;
    check("mr accept", irdy0, 1);
    repeat (4) @(negedge clk);
    iv0 = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check("mr out_valid", ov0, 0);
    check("mr in_ready", irdy0, 1);
    check("mr out_code", oc0, 8'h00);
    @(negedge clk); reset_n = 1'b1;
    repeat (12) @(negedge clk);
    check("mr no result", ov0, 0);
    check("mr idle", irdy0, 1);
    send(0, 12'h524, lat0, c0); check("mr f 524", c0, 8'hc0);
    send(1, 12'h524, lat1, c1); check("mr n 524", c1, 8'hc0);

    // Exhaustive sweep of both configurations in parallel.
    for (int l = 0; l < 4096; l++) begin
      fork
        send(0, 12'(l), lat0, c0);
        send(1, 12'(l), lat1, c1);
      join
      check($sformatf("sweep floor lin=%0h", l), c0, model_floor(l));
      check($sformatf("sweep near lin=%0h", l), c1, model_near(l));
      check($sformatf("sweep G(out)<=lin lin=%0h", l), (gt[c0] <= l), 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/inverse_gamma.md
Name: inverse_gamma

Overview:
- Converts a 12-bit linear LED intensity back into the 8-bit perceptual code that produces it. This is the reverse direction of the forward gamma curve in the LED pipeline.
- Used for readback/telemetry of framebuffer brightness and for calibration/ABL feedback paths.
- Runs a sequential 8-step binary search against the forward curve, with valid/ready handshakes on both sides.
- Forward curve, fixed: G(c) = round(4095 * (c/255)^4) for c = 0..255. G is non-decreasing, G(0..0x1a) = 0 and G(0xff) = 0xfff.

Parameters:
- ROUND_NEAREST, 0: selects the rounding mode. 0 gives the floor inverse. 1 gives the nearest code, with ties going to the lower code.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- in_valid  in  1  a linear sample is presented.
- in_ready  out  1  block accepts a sample this cycle.
- in_lin  in  12  linear intensity, 0..0xfff.
- out_valid  out  1  result is available.
- out_ready  in  1  downstream accepts the result.
- out_code  out  8  perceptual code.

Behaviour:
- Clock and reset: one clock, `clk`. Reset is asynchronous, active-low, `reset_n`.
- Reset values:
  - state = IDLE, in_ready = 1, out_valid = 0, out_code = 0x00.
  - Internal lin register, search code, and bit index all clear to 0.
- Floor result: the largest c with G(c) <= lin.
- Nearest result (ROUND_NEAREST = 1), computed from the floor result f:
  - if f == 0xff, result = f;
  - else d0 = lin - G(f), d1 = G(f+1) - lin, and result = f+1 only if d1 < d0; otherwise f.
  - Both differences are unsigned 12-bit and cannot underflow.
- State machine:
  - IDLE: in_ready = 1. On in_valid, latch in_lin, set code = 0 and bit = 7, go to SEARCH.
  - SEARCH: runs 8 cycles, bit 7 down to 0. Each cycle: trial = code | (1<<bit); if G(trial) <= lin then code = trial. Decrement bit. After the bit 0 cycle go to ROUND if ROUND_NEAREST, else DONE.
  - ROUND: 1 cycle. Apply the nearest rule using G(code+1). Go to DONE.
  - DONE: out_valid = 1, out_code held stable. When out_ready is sampled high, go to IDLE with out_valid = 0 next cycle.
- Latency and throughput:
  - Acceptance edge to out_valid is 9 cycles with ROUND_NEAREST = 0, 10 cycles with ROUND_NEAREST = 1.
  - Single outstanding transaction; in_ready = 0 outside IDLE. Maximum throughput is one sample per 10 or 11 cycles including the IDLE cycle.
- Handshake rules:
  - out_code and out_valid must not change while out_valid = 1 and out_ready = 0.
  - in_lin is sampled only on the acceptance cycle; later changes are ignored.
- Boundaries:
  - Any lin yields code >= 0x1a, because G(0x1a) = 0.
  - lin = 0xfff yields 0xff.
  - code+1 is never formed when code = 0xff, so there is no 8-bit wrap.
- Reset mid-operation: asserting reset_n low in any state aborts immediately (asynchronous). Reset values apply; no partial result is emitted.
- Curve evaluation: G is combinational from an 8-bit code, using one forward curve instance. The trial code is muxed in during SEARCH and code+1 during ROUND. No arithmetic beyond 12-bit compare and subtract.

Decomposition:
- Shared package (gamma_pkg):
  - LIN_W = 12, CODE_W = 8;
  - state enum {IDLE, SEARCH, ROUND, DONE};
  - constant CODE_MAX = 8'hff.
- One sub-module: the existing `gamma` forward LUT (8-bit in, 12-bit out, combinational), instantiated once. The curve is not duplicated.

Test Plan:
- Reset, then lin = 0x104, ROUND_NEAREST = 0 -> out_valid asserts 9 cycles after accept, out_code = 0x80. lin = 0x103 -> 0x7f.
- lin = 0x000 -> 0x1a. lin = 0xfff -> 0xff. lin = 0xffe -> 0xfe (floor) and 0xff (nearest: d0 = 0x3f, d1 = 1).
- ROUND_NEAREST = 1, lin = 0x108 (between G(0x80) = 0x104 and G(0x81) = 0x10c, a tie) -> 0x80. lin = 0x109 -> 0x81. Latency is 10 cycles.
- Backpressure: hold out_ready = 0 for 20 cycles -> out_valid and out_code stay stable, in_ready = 0, a new in_valid is ignored. Release -> the next sample is accepted only after IDLE.
- Drop reset_n mid-SEARCH (cycle 4) -> out_valid = 0, in_ready = 1 immediately. After release, a fresh lin = 0x524 gives 0xc0.
- Exhaustive: sweep all 4096 lin values against a bench model of the floor and nearest inverse of G -> zero mismatches. Also check G(out) <= lin for floor mode.
